// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv
//
// EX-stage ALU for the MIPS datapath. It combines single-cycle logic, shift and
// compare operations with an iterative multiply/divide unit that owns the HI/LO
// registers.
//
// Op codes (in_ALUOperation_4):
//   0 AND   1 OR    2 NOR   3 ADD   4 SUB   5 SLL   6 SRL   7 LUI
//   8 SRA   9 SLT  10 MULT 11 MULTU 12 DIV 13 DIVU 14 MFHI 15 MFLO
//
// Ports:
//   clk                rising-edge clock
//   reset              asynchronous, active-low reset
//   in_ALUOperation_4  operation select
//   in_A_32, in_B_32   operands (rs, rt/imm)
//   in_shamt_5         shift amount
//   in_Start           launches a mul/div (IDLE only, ops 10-13)
//   o_ALUResult_32     combinational result (0 for ops 10-13)
//   o_Zero             result == 0
//   o_Busy             mul/div iteration in progress
//   o_Done             one-cycle pulse; HI/LO already hold the new result
//   o_Overflow         signed ADD/SUB overflow (only with ALU_OVERFLOW_EN)
//
// Optional build macro: ALU_OVERFLOW_EN adds the o_Overflow port and logic.
//
// Multiply is unsigned shift-add on magnitudes and division is restoring
// shift-subtract on magnitudes; the signs are reapplied on the last step.
// -----------------------------------------------------------------------------
module alu_muldiv #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             in_ALUOperation_4,
    input  logic [DATA_WIDTH-1:0]  in_A_32,
    input  logic [DATA_WIDTH-1:0]  in_B_32,
    input  logic [SHAMT_WIDTH-1:0] in_shamt_5,
    input  logic                   in_Start,
    output logic [DATA_WIDTH-1:0]  o_ALUResult_32,
    output logic                   o_Zero,
    output logic                   o_Busy,
`ifdef ALU_OVERFLOW_EN
    output logic                   o_Done,
    output logic                   o_Overflow
`else
    output logic                   o_Done
`endif
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_NOR   = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_LUI   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_MULT  = 4'd10;
    localparam logic [3:0] OP_MULTU = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_MFHI  = 4'd14;
    localparam logic [3:0] OP_MFLO  = 4'd15;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             is_div_reg;
    logic             neg_q_reg;     // negate product / quotient
    logic             neg_r_reg;     // negate remainder (dividend sign)
    logic [W-1:0]     m_reg;         // |multiplicand| or |divisor|
    logic [W-1:0]     acc_hi_reg;    // partial product high / remainder
    logic [W-1:0]     acc_lo_reg;    // multiplier / dividend -> quotient
    logic [W-1:0]     hi_reg;
    logic [W-1:0]     lo_reg;

    // ------------------------------------------------------------------
    // Launch decode and operand magnitudes
    // ------------------------------------------------------------------
    logic         is_md_op;
    logic         launch;
    logic         op_signed;
    logic         op_div;
    logic         sign_a, sign_b;
    logic [W-1:0] abs_a, abs_b;

    assign is_md_op  = (in_ALUOperation_4 == OP_MULT) || (in_ALUOperation_4 == OP_MULTU) ||
                       (in_ALUOperation_4 == OP_DIV)  || (in_ALUOperation_4 == OP_DIVU);
    assign launch    = (state_reg == IDLE) && in_Start && is_md_op;
    assign op_signed = (in_ALUOperation_4 == OP_MULT) || (in_ALUOperation_4 == OP_DIV);
    assign op_div    = (in_ALUOperation_4 == OP_DIV)  || (in_ALUOperation_4 == OP_DIVU);
    assign sign_a    = op_signed & in_A_32[W-1];
    assign sign_b    = op_signed & in_B_32[W-1];
    // The most-negative value maps to itself, which read unsigned is 2^(W-1).
    assign abs_a     = sign_a ? -in_A_32 : in_A_32;
    assign abs_b     = sign_b ? -in_B_32 : in_B_32;

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic [W-1:0]   step_hi, step_lo;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   fin_hi, fin_lo;

    assign mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, m_reg} : {(W+1){1'b0}});
    assign div_shift = {acc_hi_reg, acc_lo_reg[W-1]};
    assign div_diff  = div_shift - {1'b0, m_reg};

    always_comb begin
        step_hi = acc_hi_reg;
        step_lo = acc_lo_reg;
        if (is_div_reg) begin
            // The remainder stays below the divisor, so bit W of the
            // difference is a reliable borrow flag.
            if (!div_diff[W]) begin
                step_hi = div_diff[W-1:0];
                step_lo = {acc_lo_reg[W-2:0], 1'b1};
            end else begin
                step_hi = div_shift[W-1:0];
                step_lo = {acc_lo_reg[W-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], acc_lo_reg[W-1:1]};
        end
    end

    // Sign fix on the final step. Divide by zero needs no special case: the
    // quotient comes out all ones and the remainder equals |A|, so the sign
    // fix yields HI = A and LO = 1 for a negative signed dividend.
    assign prod_fix = neg_q_reg ? -{step_hi, step_lo} : {step_hi, step_lo};

    always_comb begin
        if (is_div_reg) begin
            fin_lo = neg_q_reg ? -step_lo : step_lo;
            fin_hi = neg_r_reg ? -step_hi : step_hi;
        end else begin
            fin_lo = prod_fix[W-1:0];
            fin_hi = prod_fix[2*W-1:W];
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (launch) state_next = RUN;
            RUN:     if (cnt_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign o_Busy = (state_reg == RUN);
    assign o_Done = (state_reg == DONE);

    // ------------------------------------------------------------------
    // Datapath registers. HI/LO are written on the edge that enters DONE,
    // so they already show the new result while o_Done is high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            m_reg      <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            if (launch) begin
                cnt_reg    <= CNT_W'(W - 1);
                is_div_reg <= op_div;
                neg_q_reg  <= sign_a ^ sign_b;
                neg_r_reg  <= sign_a;
                m_reg      <= op_div ? abs_b : abs_a;
                acc_lo_reg <= op_div ? abs_a : abs_b;
                acc_hi_reg <= '0;
            end else if (state_reg == RUN) begin
                cnt_reg    <= cnt_reg - 1'b1;
                acc_hi_reg <= step_hi;
                acc_lo_reg <= step_lo;
                if (cnt_reg == '0) begin
                    hi_reg <= fin_hi;
                    lo_reg <= fin_lo;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Combinational result
    // ------------------------------------------------------------------
    logic [W-1:0] add_res, sub_res;
    logic         slt_bit;

    assign add_res = in_A_32 + in_B_32;
    assign sub_res = in_A_32 - in_B_32;
    assign slt_bit = $signed(in_A_32) < $signed(in_B_32);

    always_comb begin
        o_ALUResult_32 = '0;
        case (in_ALUOperation_4)
            OP_AND:  o_ALUResult_32 = in_A_32 & in_B_32;
            OP_OR:   o_ALUResult_32 = in_A_32 | in_B_32;
            OP_NOR:  o_ALUResult_32 = ~(in_A_32 | in_B_32);
            OP_ADD:  o_ALUResult_32 = add_res;
            OP_SUB:  o_ALUResult_32 = sub_res;
            OP_SLL:  o_ALUResult_32 = in_B_32 << in_shamt_5;
            OP_SRL:  o_ALUResult_32 = in_B_32 >> in_shamt_5;
            OP_LUI:  o_ALUResult_32 = in_B_32 << (W / 2);
            OP_SRA:  o_ALUResult_32 = $signed(in_B_32) >>> in_shamt_5;
            OP_SLT:  o_ALUResult_32 = {{(W-1){1'b0}}, slt_bit};
            OP_MFHI: o_ALUResult_32 = hi_reg;
            OP_MFLO: o_ALUResult_32 = lo_reg;
            default: o_ALUResult_32 = '0;   // mul/div launch codes
        endcase
    end

    assign o_Zero = (o_ALUResult_32 == '0);

`ifdef ALU_OVERFLOW_EN
    always_comb begin
        o_Overflow = 1'b0;
        if (in_ALUOperation_4 == OP_ADD)
            o_Overflow = (in_A_32[W-1] == in_B_32[W-1]) && (add_res[W-1] != in_A_32[W-1]);
        else if (in_ALUOperation_4 == OP_SUB)
            o_Overflow = (in_A_32[W-1] != in_B_32[W-1]) && (sub_res[W-1] != in_A_32[W-1]);
    end
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic [3:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic [4:0]  shamt = '0;
    logic        start = 1'b0;
    logic [31:0] res;
    logic        zero, busy, done;
`ifdef ALU_OVERFLOW_EN
    logic        ovf;
`endif

    // 16-bit instance
    logic [3:0]  op16 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [3:0]  sh16 = '0;
    logic        st16 = 1'b0;
    logic [15:0] res16;
    logic        z16, busy16, done16;
`ifdef ALU_OVERFLOW_EN
    logic        ovf16;
`endif

    alu_muldiv #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_ALUOperation_4(op), .in_A_32(a), .in_B_32(b),
        .in_shamt_5(shamt), .in_Start(start), .o_ALUResult_32(res), .o_Zero(zero),
        .o_Busy(busy),
`ifdef ALU_OVERFLOW_EN
        .o_Done(done), .o_Overflow(ovf)
`else
        .o_Done(done)
`endif
    );

    alu_muldiv #(.DATA_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .in_ALUOperation_4(op16), .in_A_32(a16), .in_B_32(b16),
        .in_shamt_5(sh16), .in_Start(st16), .o_ALUResult_32(res16), .o_Zero(z16),
        .o_Busy(busy16),
`ifdef ALU_OVERFLOW_EN
        .o_Done(done16), .o_Overflow(ovf16)
`else
        .o_Done(done16)
`endif
    );

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t sb[$];

    logic [31:0] prev_hi = '0, prev_lo = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] s, input logic [31:0] er, input string tag);
        op = o; a = x; b = y; shamt = s;
        #1;
        $display("txn %s op=%0d a=%h b=%h res=%h", tag, o, x, y, res);
        check(tag, res, er);
        check({tag, "_zero"}, 32'(zero), 32'(er == 32'd0));
    endtask

    // Launch one mul/div, count Busy/Done cycles, check HI/LO from the scoreboard.
    task automatic mdu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] ehi, input logic [31:0] elo, input string tag);
        exp_t e;
        int busy_n = 0;
        int done_n = 0;
        int done_k = 0;
        sb.push_back({ehi, elo});
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom;   // changes after launch must not matter
        for (int k = 1; k <= W + 4; k++) begin
            #1;
            if (k == 1) check({tag, "_busres"}, res, 32'd0);
            if (k == 3) begin op = 4'd10; start = 1'b1; end   // ignored in RUN
            if (k == 4) start = 1'b0;
            if (k == 5) begin
                op = 4'd14; #1 check({tag, "_mfhi_run"}, res, prev_hi);
                op = 4'd15; #1 check({tag, "_mflo_run"}, res, prev_lo);
                op = o;
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_k = k;
                if (done_n == 1 && sb.size() > 0) begin
                    e = sb.pop_front();
                    op = 4'd14; #1 check({tag, "_hi"}, res, e.hi);
                    op = 4'd15; #1 check({tag, "_lo"}, res, e.lo);
                    prev_hi = e.hi; prev_lo = e.lo;
                    $display("txn %s op=%0d hi=%h lo=%h", tag, o, e.hi, e.lo);
                    op = o;
                end
            end
            @(posedge clk); #1;
        end
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(W));
        check({tag, "_done_cycle"}, 32'(done_k), 32'(W + 1));
        check({tag, "_done_count"}, 32'(done_n), 32'd1);
    endtask

    initial begin
        int done_seen;
        int done_k16;

        // Reset state
        #12;
        check("rst_res", res, 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        op = 4'd14; #1 check("rst_hi", res, 32'd0);
        op = 4'd15; #1 check("rst_lo", res, 32'd0);
        op = 4'd0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Combinational ops
        alu(4'd3, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, "add_wrap");
`ifdef ALU_OVERFLOW_EN
        check("add_ovf", 32'(ovf), 32'd1);
        alu(4'd4, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, "sub_wrap");
        check("sub_ovf", 32'(ovf), 32'd1);
        alu(4'd3, 32'h1, 32'h1, 5'd0, 32'h2, "add_small");
        check("add_noovf", 32'(ovf), 32'd0);
`endif
        alu(4'd0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, "and");
        alu(4'd1, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0, "or");
        alu(4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h000F000F, "nor");
        alu(4'd4, 32'h5, 32'h5, 5'd0, 32'h0, "sub_zero");
        alu(4'd5, 32'h0, 32'h1, 5'd31, 32'h80000000, "sll");
        alu(4'd8, 32'h0, 32'h80000010, 5'd4, 32'hF8000001, "sra");
        alu(4'd6, 32'h0, 32'h80000010, 5'd4, 32'h08000001, "srl");
        alu(4'd7, 32'h0, 32'h00001234, 5'd0, 32'h12340000, "lui");
        alu(4'd9, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, "slt_true");
        alu(4'd9, 32'h1, 32'hFFFFFFFF, 5'd0, 32'h0, "slt_false");

        // Multiply / divide
        @(posedge clk); #1;
        mdu(4'd10, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult");
        mdu(4'd11, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, "multu");
        mdu(4'd11, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "multu_2p32");
        mdu(4'd12, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
        mdu(4'd12, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_negb");
        mdu(4'd13, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF, "divu_zero");
        mdu(4'd12, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'h00000001, "div_zero_neg");
        mdu(4'd12, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_minneg");
        mdu(4'd13, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, "divu");

        // Reset in the middle of RUN
        op = 4'd10; a = 32'hFFFFFFFD; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        op = 4'd14; #1 check("midrst_hi", res, 32'd0);
        op = 4'd15; #1 check("midrst_lo", res, 32'd0);
        $display("txn midrun_reset busy=%0d done=%0d", busy, done);
        prev_hi = '0; prev_lo = '0;
        @(negedge clk); reset = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("midrst_no_done", 32'(done_seen), 32'd0);

        // 16-bit instance
        op16 = 4'd11; a16 = 16'hFFFF; b16 = 16'hFFFF; st16 = 1'b1;
        @(posedge clk); #1;
        st16 = 1'b0;
        done_k16 = 0;
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (done16 && done_k16 == 0) done_k16 = k;
            @(posedge clk); #1;
        end
        check("w16_done_cycle", 32'(done_k16), 32'd17);
        op16 = 4'd14; #1 check("w16_hi", 32'(res16), 32'h0000FFFE);
        op16 = 4'd15; #1 check("w16_lo", 32'(res16), 32'h00000001);
        op16 = 4'd7; b16 = 16'h00AB; #1 check("w16_lui", 32'(res16), 32'h0000AB00);
        $display("txn w16 multu done_cycle=%0d", done_k16);

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
